// File: rtl/divider_scheduler_pkg.sv
// divider_scheduler_pkg
// Shared definitions for the divider scheduler slice.
// Contents:
//   sched_state_t : 2-bit encoding of the scheduler FSM (IDLE/ISSUE/WAIT/RESP)
package divider_scheduler_pkg;

    // Scheduler FSM states with fixed encodings so waveforms and any
    // downstream decode see stable values.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } sched_state_t;

endpackage

// File: rtl/divider_scheduler_divider.sv
// Divider
// Iterative restoring unsigned divider, one quotient bit per clock.
// The first step is taken on the start edge, so finished rises N cycles
// after the start cycle and quotient/remainder are valid in that cycle.
// The divisor input is used directly every step and must be held stable.
// A zero divisor yields quotient all-ones and remainder equal to dividend.
// Ports:
//   i_clock, i_reset : clock, synchronous active-high reset
//   start            : one-cycle pulse loading dividend and taking step 1
//   dividend/divisor : operands (divisor read every cycle)
//   quotient/remainder : results, valid while finished is high
//   finished         : one-cycle completion pulse
module Divider #(
    parameter int N = 8
) (
    input  logic         i_clock,
    input  logic         i_reset,
    input  logic         start,
    input  logic [N-1:0] dividend,
    input  logic [N-1:0] divisor,
    output logic [N-1:0] quotient,
    output logic [N-1:0] remainder,
    output logic         finished
);

    logic [N-1:0] step_onehot;
    logic [N-1:0] rem_q;
    logic [N-1:0] quo_q;
    logic [N-1:0] next_rem;
    logic [N-1:0] next_quo;

    // One restoring step: shift the next dividend bit into the partial
    // remainder and subtract the divisor when it fits. On start the step
    // begins from a cleared remainder and the fresh dividend.
    always_comb begin
        logic [N-1:0] src_rem;
        logic [N-1:0] src_quo;
        logic [N:0]   trial;
        logic [N:0]   diff;
        src_rem  = start ? '0 : rem_q;
        src_quo  = start ? dividend : quo_q;
        trial    = {src_rem, src_quo[N-1]};
        diff     = trial - {1'b0, divisor};
        next_rem = trial[N-1:0];
        next_quo = {src_quo[N-2:0], 1'b0};
        if (trial >= {1'b0, divisor}) begin
            next_rem = diff[N-1:0];
            next_quo = {src_quo[N-2:0], 1'b1};
        end
    end

    // Step tracker is one-hot: bit k set means k+1 steps are done. After the
    // finished cycle it clears, so a stale completion can never linger.
    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            step_onehot <= '0;
            rem_q       <= '0;
            quo_q       <= '0;
        end else if (start) begin
            step_onehot <= N'(1);
            rem_q       <= next_rem;
            quo_q       <= next_quo;
        end else if (finished) begin
            step_onehot <= '0;
        end else if (step_onehot != '0) begin
            step_onehot <= step_onehot << 1;
            rem_q       <= next_rem;
            quo_q       <= next_quo;
        end
    end

    assign finished  = step_onehot[N-1];
    assign quotient  = quo_q;
    assign remainder = rem_q;

endmodule

// File: rtl/divider_scheduler_rr_arbiter.sv
// rr_arbiter
// Combinational round-robin arbiter: grants the first asserted request at or
// after the priority pointer, wrapping from R-1 back to 0.
// Ports:
//   req       : per-requester request vector
//   pointer   : index of the highest-priority requester this cycle
//   enable    : when low no grant is produced
//   grant     : one-hot grant vector
//   grant_idx : binary index of the granted requester (0 when no grant)
module rr_arbiter #(
    parameter int R    = 4,
    parameter int ID_W = $clog2(R)
) (
    input  logic [R-1:0]    req,
    input  logic [ID_W-1:0] pointer,
    input  logic            enable,
    output logic [R-1:0]    grant,
    output logic [ID_W-1:0] grant_idx
);

    // Walk the requesters starting at the pointer; the first asserted one
    // wins. The index is reduced modulo R so non-power-of-two R wraps
    // correctly.
    always_comb begin
        logic            found;
        logic [ID_W-1:0] idx;
        grant     = '0;
        grant_idx = '0;
        found     = 1'b0;
        idx       = '0;
        for (int i = 0; i < R; i++) begin
            idx = ID_W'((int'(pointer) + i) % R);
            if (enable && !found && req[idx]) begin
                grant[idx] = 1'b1;
                grant_idx  = idx;
                found      = 1'b1;
            end
        end
    end

endmodule

// File: rtl/divider_scheduler.sv
// divider_scheduler
// Shares one iterative Divider among R requesters. Requests are accepted
// round-robin, operands are latched and held on the divider, and each result
// is returned on a single response channel tagged with the requester index.
// A zero divisor bypasses the divider and answers directly.
// Ports:
//   i_clock, i_reset   : clock, synchronous active-high reset
//   i_req_valid        : per-requester request valid
//   o_req_ready        : one-hot accept strobe, high only in the accept cycle
//   i_req_dividend/divisor : requester k operands in bits [k*N +: N]
//   o_rsp_valid / i_rsp_ready : response handshake
//   o_rsp_id, o_rsp_quotient, o_rsp_remainder, o_rsp_div_by_zero : response
//   o_busy             : high whenever the FSM is not IDLE
module divider_scheduler
    import divider_scheduler_pkg::*;
#(
    parameter int N    = 8,
    parameter int R    = 4,
    parameter int ID_W = $clog2(R)
) (
    input  logic            i_clock,
    input  logic            i_reset,
    input  logic [R-1:0]    i_req_valid,
    output logic [R-1:0]    o_req_ready,
    input  logic [R*N-1:0]  i_req_dividend,
    input  logic [R*N-1:0]  i_req_divisor,
    output logic            o_rsp_valid,
    input  logic            i_rsp_ready,
    output logic [ID_W-1:0] o_rsp_id,
    output logic [N-1:0]    o_rsp_quotient,
    output logic [N-1:0]    o_rsp_remainder,
    output logic            o_rsp_div_by_zero,
    output logic            o_busy
);

    sched_state_t    state_q;
    sched_state_t    state_d;
    logic [ID_W-1:0] pointer_q;
    logic [ID_W-1:0] id_q;
    logic [N-1:0]    dividend_q;
    logic [N-1:0]    divisor_q;
    logic [N-1:0]    rsp_quotient_q;
    logic [N-1:0]    rsp_remainder_q;
    logic            rsp_dbz_q;
    logic [R-1:0]    grant;
    logic [ID_W-1:0] grant_idx;
    logic            accept;
    logic [N-1:0]    sel_dividend;
    logic [N-1:0]    sel_divisor;
    logic            div_start;
    logic            div_finished;
    logic [N-1:0]    div_quotient;
    logic [N-1:0]    div_remainder;

    // Arbitration only runs in IDLE and is suppressed during reset so the
    // accept strobe reads zero while reset is held.
    rr_arbiter #(.R(R), .ID_W(ID_W)) u_arbiter (
        .req       (i_req_valid),
        .pointer   (pointer_q),
        .enable    ((state_q == IDLE) && !i_reset),
        .grant     (grant),
        .grant_idx (grant_idx)
    );

    assign accept       = |grant;
    assign sel_dividend = i_req_dividend[grant_idx*N +: N];
    assign sel_divisor  = i_req_divisor[grant_idx*N +: N];

    // Operands come from the latches on every cycle because the divider
    // re-reads its divisor each step.
    Divider #(.N(N)) u_divider (
        .i_clock   (i_clock),
        .i_reset   (i_reset),
        .start     (div_start),
        .dividend  (dividend_q),
        .divisor   (divisor_q),
        .quotient  (div_quotient),
        .remainder (div_remainder),
        .finished  (div_finished)
    );

    // State register.
    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic. Start is only ever raised in ISSUE, which keeps a
    // single operation in flight. A zero divisor skips straight to RESP.
    always_comb begin
        state_d   = state_q;
        div_start = 1'b0;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    state_d = (sel_divisor != '0) ? ISSUE : RESP;
                end
            end
            ISSUE: begin
                div_start = 1'b1;
                state_d   = WAIT;
            end
            WAIT: begin
                if (div_finished) begin
                    state_d = RESP;
                end
            end
            RESP: begin
                if (i_rsp_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Datapath: latch the accepted request and advance the pointer past the
    // winner; load the response either immediately (bypass) or from the
    // divider in its single finished cycle. Response fields then hold until
    // the next operation overwrites them.
    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            pointer_q       <= '0;
            id_q            <= '0;
            dividend_q      <= '0;
            divisor_q       <= '0;
            rsp_quotient_q  <= '0;
            rsp_remainder_q <= '0;
            rsp_dbz_q       <= 1'b0;
        end else begin
            if (accept) begin
                pointer_q  <= (grant_idx == ID_W'(R - 1)) ? '0 : grant_idx + 1'b1;
                id_q       <= grant_idx;
                dividend_q <= sel_dividend;
                divisor_q  <= sel_divisor;
                if (sel_divisor == '0) begin
                    rsp_quotient_q  <= '1;
                    rsp_remainder_q <= sel_dividend;
                    rsp_dbz_q       <= 1'b1;
                end
            end
            if ((state_q == WAIT) && div_finished) begin
                rsp_quotient_q  <= div_quotient;
                rsp_remainder_q <= div_remainder;
                rsp_dbz_q       <= 1'b0;
            end
        end
    end

    assign o_req_ready       = grant;
    assign o_rsp_valid       = (state_q == RESP);
    assign o_rsp_id          = id_q;
    assign o_rsp_quotient    = rsp_quotient_q;
    assign o_rsp_remainder   = rsp_remainder_q;
    assign o_rsp_div_by_zero = rsp_dbz_q;
    assign o_busy            = (state_q != IDLE);

endmodule

// File: tb/tb_divider_scheduler.sv
// tb_divider_scheduler
// Self-checking bench for divider_scheduler (N=8, R=4). Accepted requests
// push their expected response into a scoreboard; an independent monitor
// pops and compares each response when it is handshaken.
module tb_divider_scheduler;

    localparam int N    = 8;
    localparam int R    = 4;
    localparam int ID_W = 2;

    logic            clock = 1'b0;
    logic            reset;
    logic [R-1:0]    reqValid;
    logic [R-1:0]    reqReady;
    logic [R*N-1:0]  reqDividend;
    logic [R*N-1:0]  reqDivisor;
    logic            rspValid;
    logic            rspReady;
    logic [ID_W-1:0] rspId;
    logic [N-1:0]    rspQuotient;
    logic [N-1:0]    rspRemainder;
    logic            rspDbz;
    logic            busy;

    typedef struct {
        int id;
        int quo;
        int rem;
        int dbz;
        int acceptCycle;
        int latency;
    } expect_t;

    expect_t sb[$];
    int      grantLog[$];
    int      testsRun    = 0;
    int      testsFailed = 0;
    int      cycle       = 0;
    int      tbPtr       = 0;
    bit      accepted[R];
    int      lastAcceptCycle = 0;
    int      lastHsCycle     = 0;

    divider_scheduler #(.N(N), .R(R), .ID_W(ID_W)) dut (
        .i_clock           (clock),
        .i_reset           (reset),
        .i_req_valid       (reqValid),
        .o_req_ready       (reqReady),
        .i_req_dividend    (reqDividend),
        .i_req_divisor     (reqDivisor),
        .o_rsp_valid       (rspValid),
        .i_rsp_ready       (rspReady),
        .o_rsp_id          (rspId),
        .o_rsp_quotient    (rspQuotient),
        .o_rsp_remainder   (rspRemainder),
        .o_rsp_div_by_zero (rspDbz),
        .o_busy            (busy)
    );

    // Free-running clock and cycle counter.
    always #5 clock = ~clock;
    always @(posedge clock) cycle++;

    // Absolute bound on the run.
    initial begin
        #1000000;
        $display("[TB] FAIL watchdog: simulation did not finish, got running expected done");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string name, input int actual, input int expected);
        testsRun++;
        if (actual != expected) begin
            testsFailed++;
            $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
        end
    endtask

    task automatic reportFail(input string name, input string detail);
        testsRun++;
        testsFailed++;
        $display("[TB] FAIL %s: %s", name, detail);
    endtask

    // Round-robin rule: first valid at or after the priority pointer.
    function automatic int modelGrant(input logic [R-1:0] v, input int ptr);
        for (int i = 0; i < R; i++) begin
            if (v[(ptr + i) % R]) return (ptr + i) % R;
        end
        return -1;
    endfunction

    // Accept monitor: verify the grant and push the expected response.
    always @(negedge clock) begin
        if (!reset && reqReady != '0) begin
            int g;
            int dvd;
            int dvs;
            expect_t e;
            g = 0;
            for (int k = R - 1; k >= 0; k--) if (reqReady[k]) g = k;
            checkOutput("ready_onehot", $countones(reqReady), 1);
            checkOutput("ready_while_busy", int'(busy), 0);
            checkOutput("grant_rr", g, modelGrant(reqValid, tbPtr));
            dvd = int'(reqDividend[g*N +: N]);
            dvs = int'(reqDivisor[g*N +: N]);
            e.id          = g;
            e.acceptCycle = cycle;
            if (dvs == 0) begin
                e.quo = (1 << N) - 1;
                e.rem = dvd;
                e.dbz = 1;
                e.latency = 1;
            end else begin
                e.quo = dvd / dvs;
                e.rem = dvd % dvs;
                e.dbz = 0;
                e.latency = N + 2;
            end
            sb.push_back(e);
            grantLog.push_back(g);
            tbPtr = (g + 1) % R;
            accepted[g] = 1'b1;
            lastAcceptCycle = cycle;
        end
    end

    // Response monitor: latency on first presentation, stability while
    // stalled, and scoreboard comparison on the handshake.
    always @(negedge clock) begin
        static bit held = 1'b0;
        static int heldId = 0, heldQ = 0, heldR = 0, heldDbz = 0;
        if (reset) begin
            held = 1'b0;
        end else begin
            if (rspValid) begin
                checkOutput("rsp_busy", int'(busy), 1);
                checkOutput("rsp_no_ready", int'(reqReady), 0);
                if (!held) begin
                    if (sb.size() == 0) begin
                        reportFail("spurious_rsp", $sformatf("got response id %0d, expected none", rspId));
                    end else begin
                        checkOutput("rsp_latency", cycle - sb[0].acceptCycle, sb[0].latency);
                    end
                end else begin
                    checkOutput("hold_id", int'(rspId), heldId);
                    checkOutput("hold_q", int'(rspQuotient), heldQ);
                    checkOutput("hold_r", int'(rspRemainder), heldR);
                    checkOutput("hold_dbz", int'(rspDbz), heldDbz);
                end
                if (rspReady && sb.size() != 0) begin
                    expect_t e;
                    e = sb.pop_front();
                    checkOutput("rsp_id", int'(rspId), e.id);
                    checkOutput("rsp_quotient", int'(rspQuotient), e.quo);
                    checkOutput("rsp_remainder", int'(rspRemainder), e.rem);
                    checkOutput("rsp_dbz", int'(rspDbz), e.dbz);
                    lastHsCycle = cycle;
                end
                heldId = int'(rspId);
                heldQ = int'(rspQuotient);
                heldR = int'(rspRemainder);
                heldDbz = int'(rspDbz);
            end
            held = rspValid && !rspReady;
        end
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // Raise one request and hold it until it is accepted.
    task automatic applyStimulus(input int k, input int dvd, input int dvs);
        accepted[k] = 1'b0;
        reqValid[k] = 1'b1;
        reqDividend[k*N +: N] = N'(dvd);
        reqDivisor[k*N +: N]  = N'(dvs);
        for (int i = 0; i < 100 && !accepted[k]; i++) tick();
        if (!accepted[k]) reportFail("accept_timeout", $sformatf("requester %0d got no grant, expected one", k));
        reqValid[k] = 1'b0;
        accepted[k] = 1'b0;
    endtask

    task automatic waitIdle();
        int i;
        for (i = 0; i < 300 && (sb.size() != 0 || busy); i++) tick();
        if (sb.size() != 0 || busy) reportFail("idle_timeout", $sformatf("got %0d pending, expected 0", sb.size()));
    endtask

    task automatic checkResetOutputs(input string tag);
        checkOutput({tag, "_ready"}, int'(reqReady), 0);
        checkOutput({tag, "_rsp_valid"}, int'(rspValid), 0);
        checkOutput({tag, "_rsp_id"}, int'(rspId), 0);
        checkOutput({tag, "_rsp_q"}, int'(rspQuotient), 0);
        checkOutput({tag, "_rsp_r"}, int'(rspRemainder), 0);
        checkOutput({tag, "_rsp_dbz"}, int'(rspDbz), 0);
        checkOutput({tag, "_busy"}, int'(busy), 0);
    endtask

    initial begin
        reset       = 1'b1;
        reqValid    = '0;
        reqDividend = '0;
        reqDivisor  = '0;
        rspReady    = 1'b1;
        repeat (3) tick();
        reset = 1'b0;
        @(negedge clock);
        checkResetOutputs("reset");
        tick();

        // Contention: all four valid continuously, grant order 0,1,2,3,0.
        $display("[TB] contention");
        grantLog.delete();
        for (int k = 0; k < R; k++) begin
            accepted[k] = 1'b0;
            reqValid[k] = 1'b1;
            reqDividend[k*N +: N] = N'(50 + 10 * k);
            reqDivisor[k*N +: N]  = N'(k + 3);
        end
        for (int i = 0; i < 300 && grantLog.size() < 5; i++) begin
            tick();
            for (int k = 0; k < R; k++) begin
                if (accepted[k]) begin
                    accepted[k] = 1'b0;
                    reqDividend[k*N +: N] = N'($urandom_range(0, 255));
                    reqDivisor[k*N +: N]  = N'($urandom_range(1, 255));
                end
            end
        end
        reqValid = '0;
        for (int k = 0; k < R; k++) accepted[k] = 1'b0;
        checkOutput("grant_count", grantLog.size(), 5);
        for (int i = 0; i < 5 && i < grantLog.size(); i++) checkOutput("grant_order", grantLog[i], i % R);
        waitIdle();

        // Single request: requester 1, 200/7 -> 28 r 4.
        $display("[TB] single request");
        applyStimulus(1, 200, 7);
        waitIdle();

        // Divide by zero bypass: requester 2, 45/0.
        $display("[TB] divide by zero");
        applyStimulus(2, 45, 0);
        waitIdle();

        // Backpressure: response stalled 5 cycles, a waiting request is
        // granted the cycle after the handshake.
        $display("[TB] backpressure");
        rspReady = 1'b0;
        applyStimulus(3, 100, 9);
        for (int i = 0; i < 50 && !rspValid; i++) tick();
        checkOutput("bp_rsp_valid", int'(rspValid), 1);
        accepted[0] = 1'b0;
        reqValid[0] = 1'b1;
        reqDividend[0 +: N] = N'(77);
        reqDivisor[0 +: N]  = N'(5);
        repeat (5) tick();
        checkOutput("bp_no_grant", int'(accepted[0]), 0);
        rspReady = 1'b1;
        for (int i = 0; i < 20 && !accepted[0]; i++) tick();
        checkOutput("bp_granted", int'(accepted[0]), 1);
        checkOutput("grant_after_hs", lastAcceptCycle, lastHsCycle + 1);
        reqValid[0] = 1'b0;
        accepted[0] = 1'b0;
        waitIdle();

        // Reset three cycles after start, then a fresh 9/3 request.
        $display("[TB] reset in WAIT");
        applyStimulus(1, 250, 13);
        repeat (3) tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        sb.delete();
        tbPtr = 0;
        for (int k = 0; k < R; k++) accepted[k] = 1'b0;
        @(negedge clock);
        checkResetOutputs("midreset");
        tick();
        reqValid[0] = 1'b1;
        reqDividend[0 +: N] = N'(9);
        reqDivisor[0 +: N]  = N'(3);
        reqValid[3] = 1'b1;
        reqDividend[3*N +: N] = N'(17);
        reqDivisor[3*N +: N]  = N'(5);
        for (int i = 0; i < 100 && reqValid != '0; i++) begin
            tick();
            for (int k = 0; k < R; k++) begin
                if (accepted[k]) begin
                    accepted[k] = 1'b0;
                    reqValid[k] = 1'b0;
                end
            end
        end
        checkOutput("post_reset_accepts", int'(reqValid), 0);
        reqValid = '0;
        waitIdle();

        // Boundaries.
        $display("[TB] boundaries");
        applyStimulus(0, 255, 1);
        applyStimulus(1, 3, 200);
        applyStimulus(2, 255, 255);
        applyStimulus(3, 0, 0);
        waitIdle();

        // Randomized traffic with random response backpressure.
        $display("[TB] random traffic");
        for (int c = 0; c < 600; c++) begin
            tick();
            rspReady = ($urandom_range(0, 3) != 0);
            for (int k = 0; k < R; k++) begin
                if (accepted[k]) begin
                    accepted[k] = 1'b0;
                    reqValid[k] = 1'b0;
                end
                if (!reqValid[k] && $urandom_range(0, 2) == 0) begin
                    reqValid[k] = 1'b1;
                    reqDividend[k*N +: N] = N'($urandom_range(0, 255));
                    reqDivisor[k*N +: N]  = ($urandom_range(0, 7) == 0) ? '0 : N'($urandom_range(1, 255));
                end
            end
        end
        reqValid = '0;
        rspReady = 1'b1;
        tick();
        waitIdle();

        checkOutput("sb_empty", sb.size(), 0);
        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
